// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue memory path.
// Holds the LSQ geometry, the memory scheduler FSM state encoding and the
// memory operation type used by the scheduler and its helpers.
package lsq_pkg;

  localparam int DEPTH        = 16;  // LSQ entries, power of two
  localparam int IDXW         = 4;   // log2(DEPTH)
  localparam int STARVE_LIMIT = 4;   // store grants tolerated while loads wait

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/age_prio_pick.sv
// Age-ordered priority picker over a circular queue.
// Finds the oldest set bit of req_vec, where age is measured from origin
// (the queue head) and wraps modulo DEPTH.
// Ports:
//   req_vec  in   DEPTH  candidate entries
//   origin   in   IDXW   index of the oldest entry
//   found    out  1      at least one candidate present
//   idx      out  IDXW   index of the oldest candidate (0 when none)
module age_prio_pick import lsq_pkg::*; #(
  parameter int DEPTH = lsq_pkg::DEPTH,
  parameter int IDXW  = lsq_pkg::IDXW
) (
  input  logic [DEPTH-1:0] req_vec,
  input  logic [IDXW-1:0]  origin,
  output logic             found,
  output logic [IDXW-1:0]  idx
);

  logic [2*DEPTH-1:0] dbl_vec;
  logic [DEPTH-1:0]   rot_vec;
  logic [IDXW-1:0]    pos;

  // Shifting a doubled copy right gives a rotate; bit 0 is then the head.
  assign dbl_vec = {req_vec, req_vec} >> origin;
  assign rot_vec = dbl_vec[DEPTH-1:0];

  // Descending scan so the lowest set bit (the oldest entry) wins.
  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rot_vec[i]) begin
        found = 1'b1;
        pos   = IDXW'(i);
      end
    end
  end

  // Un-rotate: IDXW-bit addition wraps naturally modulo DEPTH.
  assign idx = found ? (pos + origin) : '0;

endmodule

// File: rtl/lsq_mem_scheduler.sv
// Memory port scheduler for the load/store queue.
// Grants the single data-memory port to either the committed store at the
// LSQ head or the oldest address-ready load, runs the req/ready/resp
// handshake (one access outstanding) and reports completion to the LSQ.
// Speculative loads are dropped on flush; committed stores always finish.
// Ports:
//   clk, reset (sync, active-high)
//   lsq_head, ld_ready, st_commit_valid, st_commit_idx, flush : LSQ side in
//   issue_valid, issue_idx, issue_is_store                     : grant out
//   mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid   : memory side
//   ld_done_valid, st_done_valid                               : completion
//   busy                                                       : not IDLE
module lsq_mem_scheduler import lsq_pkg::*; #(
  parameter int DEPTH        = lsq_pkg::DEPTH,
  parameter int IDXW         = lsq_pkg::IDXW,
  parameter int STARVE_LIMIT = lsq_pkg::STARVE_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDXW-1:0]  lsq_head,
  input  logic [DEPTH-1:0] ld_ready,
  input  logic             st_commit_valid,
  input  logic [IDXW-1:0]  st_commit_idx,
  input  logic             flush,
  output logic             issue_valid,
  output logic [IDXW-1:0]  issue_idx,
  output logic             issue_is_store,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_we,
  input  logic             mem_resp_valid,
  output logic             ld_done_valid,
  output logic             st_done_valid,
  output logic             busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  sched_state_t    state_q, state_d;
  logic            issue_valid_q, issue_valid_d;
  logic [IDXW-1:0] issue_idx_q, issue_idx_d;
  mem_op_t         op_q, op_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic            any_ld;
  logic            force_load;
  logic            is_store;

  age_prio_pick #(.DEPTH(DEPTH), .IDXW(IDXW)) u_pick (
    .req_vec (ld_ready),
    .origin  (lsq_head),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  assign any_ld     = |ld_ready;
  assign force_load = (starve_q == SW'(STARVE_LIMIT)) && any_ld;
  assign is_store   = (op_q == STORE);

  always_comb begin
    state_d       = state_q;
    issue_valid_d = 1'b0;
    issue_idx_d   = issue_idx_q;
    op_d          = op_q;
    starve_d      = starve_q;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (st_commit_valid && !force_load) begin
            issue_valid_d = 1'b1;
            issue_idx_d   = st_commit_idx;
            op_d          = STORE;
            state_d       = REQ;
            if (any_ld && starve_q != SW'(STARVE_LIMIT)) begin
              starve_d = starve_q + 1'b1;
            end
          end else if (pick_found) begin
            issue_valid_d = 1'b1;
            issue_idx_d   = pick_idx;
            op_d          = LOAD;
            state_d       = REQ;
            starve_d      = '0;
          end
        end
      end
      REQ: begin
        // A flushed load is withdrawn before memory sees it (req is masked).
        if (flush && !is_store) begin
          state_d = IDLE;
        end else if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
        end else if (flush && !is_store) begin
          // Response is still owed by memory; swallow it silently.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      op_q          <= LOAD;
      starve_q      <= '0;
    end else begin
      state_q       <= state_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      op_q          <= op_d;
      starve_q      <= starve_d;
    end
  end

  assign issue_valid    = issue_valid_q;
  assign issue_idx      = issue_idx_q;
  assign issue_is_store = is_store;
  assign mem_req_valid  = (state_q == REQ) && !(flush && !is_store);
  assign mem_req_we     = is_store;
  assign ld_done_valid  = (state_q == WAIT) && mem_resp_valid && !is_store && !flush;
  assign st_done_valid  = (state_q == WAIT) && mem_resp_valid && is_store;
  assign busy           = (state_q != IDLE);

endmodule
